// File: rtl/branch_resolution_unit.sv
// -----------------------------------------------------------------------------
// branch_resolution_unit
//
// Resolve side of the branch predictor. Each prediction made at IF
// (PC, direction, target and the global-history snapshot) is queued in a
// DEPTH-entry FIFO. When the matching instruction reaches EX, its real
// outcome is compared with the queued prediction. On a mismatch the unit
// asserts a flush and a redirect, and repairs the global history. One cycle
// after any resolved control-transfer instruction, it emits a predictor
// training write.
//
// Ports
//   clk, reset               clock (rising edge); asynchronous active-low reset
//   pred_valid/pred_ready    enqueue handshake from IF
//   pred_pc/taken/target     prediction made at IF
//   pred_bhsr                global history snapshot used for the prediction
//   res_valid, res_pc        instruction present in EX and its PC
//   res_is_branch/jal/jalr   instruction class in EX
//   res_bcond, res_target    branch condition and computed target
//   is_flush, redirect_pc    misprediction kill and correct next PC
//   bhsr_restore_valid/_     global history repair
//   upd_*                    registered BTB / gshare training write
//   err                      sticky protocol error (EX PC does not match head)
//   mispredict_cnt           saturating flush count
//   resolved_cnt             saturating resolution count
// -----------------------------------------------------------------------------
module branch_resolution_unit #(
    parameter int ENTRY_BIT = 5,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pred_valid,
    output logic                    pred_ready,
    input  logic [31:0]             pred_pc,
    input  logic                    pred_taken,
    input  logic [31:0]             pred_target,
    input  logic [ENTRY_BIT-1:0]    pred_bhsr,
    input  logic                    res_valid,
    input  logic [31:0]             res_pc,
    input  logic                    res_is_branch,
    input  logic                    res_is_jal,
    input  logic                    res_is_jalr,
    input  logic                    res_bcond,
    input  logic [31:0]             res_target,
    output logic                    is_flush,
    output logic [31:0]             redirect_pc,
    output logic                    bhsr_restore_valid,
    output logic [ENTRY_BIT-1:0]    bhsr_restore,
    output logic                    upd_valid,
    output logic [ENTRY_BIT-1:0]    upd_idx,
    output logic [29-ENTRY_BIT:0]   upd_tag,
    output logic [31:0]             upd_target,
    output logic                    upd_is_branch,
    output logic                    upd_taken,
    output logic [ENTRY_BIT-1:0]    upd_cnt_idx,
    output logic                    err,
    output logic [CNT_W-1:0]        mispredict_cnt,
    output logic [CNT_W-1:0]        resolved_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    // Prediction FIFO storage; only the head is read, combinationally, since
    // resolution must happen in the same cycle the instruction sits in EX.
    logic [31:0]          pc_mem     [DEPTH];
    logic                 taken_mem  [DEPTH];
    logic [31:0]          target_mem [DEPTH];
    logic [ENTRY_BIT-1:0] bhsr_mem   [DEPTH];

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;

    logic [31:0]          h_pc;
    logic                 h_taken;
    logic [31:0]          h_target;
    logic [ENTRY_BIT-1:0] h_bhsr;

    logic        hit;
    logic        pop;
    logic        enq;
    logic        is_ctrl;
    logic        actual_taken;
    logic [31:0] actual_next;
    logic [31:0] pred_next;
    logic        flush;

    assign h_pc     = pc_mem[head_reg];
    assign h_taken  = taken_mem[head_reg];
    assign h_target = target_mem[head_reg];
    assign h_bhsr   = bhsr_mem[head_reg];

    assign pred_ready = (count_reg != (PTR_W+1)'(DEPTH));
    assign enq        = pred_valid & pred_ready;

    assign hit          = (count_reg != '0) && (h_pc == res_pc);
    assign pop          = res_valid & hit;
    assign is_ctrl      = res_is_branch | res_is_jal | res_is_jalr;
    assign actual_taken = res_is_jal | res_is_jalr | (res_is_branch & res_bcond);
    assign actual_next  = actual_taken ? res_target : res_pc + 32'd4;
    assign pred_next    = h_taken ? h_target : h_pc + 32'd4;
    assign flush        = pop & (actual_next != pred_next);

    // Outputs are gated so that nothing stale (unreset FIFO contents) leaks
    // onto the redirect or history buses when there is no resolution.
    always_comb begin
        is_flush           = flush;
        bhsr_restore_valid = flush;
        redirect_pc        = 32'd0;
        bhsr_restore       = '0;
        if (pop) begin
            redirect_pc = actual_next;
        end
        if (flush) begin
            // A conditional branch shifts its real outcome into the snapshot;
            // jumps never entered the history, so the snapshot is restored as-is.
            bhsr_restore = res_is_branch ? {h_bhsr[ENTRY_BIT-2:0], res_bcond} : h_bhsr;
        end
    end

    // FIFO write port. Wrong-path enqueues coinciding with a flush are dropped.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            pc_mem[tail_reg]     <= pred_pc;
            taken_mem[tail_reg]  <= pred_taken;
            target_mem[tail_reg] <= pred_target;
            bhsr_mem[tail_reg]   <= pred_bhsr;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            // Every younger entry is on the wrong path: empty the queue.
            head_reg  <= tail_reg;
            count_reg <= '0;
        end else begin
            if (enq) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            if (enq && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!enq && pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Training write, one cycle after a resolved control transfer.
    // Fields hold their value between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_valid     <= 1'b0;
            upd_idx       <= '0;
            upd_tag       <= '0;
            upd_target    <= 32'd0;
            upd_is_branch <= 1'b0;
            upd_taken     <= 1'b0;
            upd_cnt_idx   <= '0;
        end else begin
            upd_valid <= pop & is_ctrl;
            if (pop && is_ctrl) begin
                upd_idx       <= res_pc[ENTRY_BIT+1:2];
                upd_tag       <= res_pc[31:ENTRY_BIT+2];
                upd_target    <= res_target;
                upd_is_branch <= res_is_branch;
                upd_taken     <= actual_taken;
                upd_cnt_idx   <= res_pc[ENTRY_BIT+1:2] ^ h_bhsr;
            end
        end
    end

    // Sticky error and saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err            <= 1'b0;
            mispredict_cnt <= '0;
            resolved_cnt   <= '0;
        end else begin
            if (res_valid && !hit) begin
                err <= 1'b1;
            end
            if (pop && (resolved_cnt != '1)) begin
                resolved_cnt <= resolved_cnt + 1'b1;
            end
            if (flush && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolution_unit
//
// Directed bench for branch_resolution_unit (counters narrowed to 4 bits).
// Expected training writes are queued when a resolution is driven and popped
// when upd_valid is sampled in the following cycle.
// -----------------------------------------------------------------------------
module tb_branch_resolution_unit;

    localparam int EB = 5;
    localparam int CW = 4;

    typedef struct {
        logic [EB-1:0] idx;
        logic [29-EB:0] tag;
        logic [31:0]   target;
        logic          is_branch;
        logic          taken;
        logic [EB-1:0] cnt_idx;
    } upd_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           pred_valid;
    logic           pred_ready;
    logic [31:0]    pred_pc;
    logic           pred_taken;
    logic [31:0]    pred_target;
    logic [EB-1:0]  pred_bhsr;
    logic           res_valid;
    logic [31:0]    res_pc;
    logic           res_is_branch;
    logic           res_is_jal;
    logic           res_is_jalr;
    logic           res_bcond;
    logic [31:0]    res_target;
    logic           is_flush;
    logic [31:0]    redirect_pc;
    logic           bhsr_restore_valid;
    logic [EB-1:0]  bhsr_restore;
    logic           upd_valid;
    logic [EB-1:0]  upd_idx;
    logic [29-EB:0] upd_tag;
    logic [31:0]    upd_target;
    logic           upd_is_branch;
    logic           upd_taken;
    logic [EB-1:0]  upd_cnt_idx;
    logic           err;
    logic [CW-1:0]  mispredict_cnt;
    logic [CW-1:0]  resolved_cnt;

    int   n_assert = 0;
    int   n_fail   = 0;
    upd_t sb[$];

    branch_resolution_unit #(.ENTRY_BIT(EB), .DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_bhsr(pred_bhsr),
        .res_valid(res_valid), .res_pc(res_pc), .res_is_branch(res_is_branch),
        .res_is_jal(res_is_jal), .res_is_jalr(res_is_jalr), .res_bcond(res_bcond),
        .res_target(res_target), .is_flush(is_flush), .redirect_pc(redirect_pc),
        .bhsr_restore_valid(bhsr_restore_valid), .bhsr_restore(bhsr_restore),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_tag(upd_tag),
        .upd_target(upd_target), .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
        .upd_cnt_idx(upd_cnt_idx), .err(err), .mispredict_cnt(mispredict_cnt),
        .resolved_cnt(resolved_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts and ends at posedge+1.
    task automatic enq(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [EB-1:0] bh);
        pred_valid  = 1'b1;
        pred_pc     = pc;
        pred_taken  = tk;
        pred_target = tgt;
        pred_bhsr   = bh;
        @(posedge clk); #1;
        pred_valid = 1'b0;
        $display("enq     pc=%h taken=%0d target=%h bhsr=%b ready_after=%0d", pc, tk, tgt, bh, pred_ready);
    endtask

    // Drives one EX resolution, checks the combinational response mid-cycle,
    // then checks the registered training write and err one cycle later.
    task automatic resolve(input logic [31:0] pc, input logic br, input logic jal,
                           input logic jalr, input logic bc, input logic [31:0] tgt,
                           input logic [EB-1:0] snap, input logic exp_flush,
                           input logic [31:0] exp_redirect, input logic [EB-1:0] exp_restore,
                           input logic exp_upd, input logic exp_err);
        upd_t e;
        res_valid     = 1'b1;
        res_pc        = pc;
        res_is_branch = br;
        res_is_jal    = jal;
        res_is_jalr   = jalr;
        res_bcond     = bc;
        res_target    = tgt;
        #4;
        chk("is_flush", 32'(is_flush), 32'(exp_flush));
        chk("bhsr_restore_valid", 32'(bhsr_restore_valid), 32'(exp_flush));
        if (exp_flush) begin
            chk("redirect_pc", redirect_pc, exp_redirect);
            chk("bhsr_restore", 32'(bhsr_restore), 32'(exp_restore));
        end
        if (exp_upd) begin
            e.idx       = pc[EB+1:2];
            e.tag       = pc[31:EB+2];
            e.target    = tgt;
            e.is_branch = br;
            e.taken     = jal | jalr | (br & bc);
            e.cnt_idx   = pc[EB+1:2] ^ snap;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        res_valid = 1'b0;
        #4;
        chk("upd_valid", 32'(upd_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("upd_idx", 32'(upd_idx), 32'(e.idx));
            chk("upd_tag", 32'(upd_tag), 32'(e.tag));
            chk("upd_target", upd_target, e.target);
            chk("upd_is_branch", 32'(upd_is_branch), 32'(e.is_branch));
            chk("upd_taken", 32'(upd_taken), 32'(e.taken));
            chk("upd_cnt_idx", 32'(upd_cnt_idx), 32'(e.cnt_idx));
        end
        chk("err", 32'(err), 32'(exp_err));
        $display("resolve pc=%h br=%0d jal=%0d jalr=%0d bcond=%0d target=%h flush_exp=%0d upd_exp=%0d err=%0d",
                 pc, br, jal, jalr, bc, tgt, exp_flush, exp_upd, err);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0; pred_bhsr = 0;
        res_valid = 0; res_pc = 0; res_is_branch = 0; res_is_jal = 0; res_is_jalr = 0;
        res_bcond = 0; res_target = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst pred_ready", 32'(pred_ready), 32'd1);
        chk("rst is_flush", 32'(is_flush), 32'd0);
        chk("rst redirect_pc", redirect_pc, 32'd0);
        chk("rst bhsr_restore_valid", 32'(bhsr_restore_valid), 32'd0);
        chk("rst upd_valid", 32'(upd_valid), 32'd0);
        chk("rst upd_target", upd_target, 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst mispredict_cnt", 32'(mispredict_cnt), 32'd0);
        chk("rst resolved_cnt", 32'(resolved_cnt), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Non-control instruction, correctly predicted not-taken
        enq(32'h100, 1'b0, 32'h0, 5'b00000);
        resolve(32'h100, 0, 0, 0, 0, 32'h0, 5'b00000, 1'b0, 32'h0, 5'b0, 1'b0, 1'b0);
        chk("t1 pred_ready", 32'(pred_ready), 32'd1);

        // Branch predicted not-taken but taken
        enq(32'h200, 1'b0, 32'h0, 5'b00110);
        resolve(32'h200, 1, 0, 0, 1, 32'h240, 5'b00110, 1'b1, 32'h240, 5'b01101, 1'b1, 1'b0);

        // jalr with wrong target; three younger entries discarded
        enq(32'h300, 1'b1, 32'h400, 5'b10101);
        enq(32'h304, 1'b0, 32'h0, 5'b00001);
        enq(32'h308, 1'b0, 32'h0, 5'b00010);
        enq(32'h30C, 1'b0, 32'h0, 5'b00011);
        chk("t3 full pred_ready", 32'(pred_ready), 32'd0);
        resolve(32'h300, 0, 0, 1, 0, 32'h480, 5'b10101, 1'b1, 32'h480, 5'b10101, 1'b1, 1'b0);
        chk("t3 pred_ready after flush", 32'(pred_ready), 32'd1);
        chk("t3 mispredict_cnt", 32'(mispredict_cnt), 32'd2);
        chk("t3 resolved_cnt", 32'(resolved_cnt), 32'd3);

        // Fill, overflow attempt, then drain in order
        enq(32'h500, 1'b0, 32'h0, 5'b0);
        enq(32'h504, 1'b0, 32'h0, 5'b0);
        enq(32'h508, 1'b0, 32'h0, 5'b0);
        enq(32'h50C, 1'b0, 32'h0, 5'b0);
        chk("t4 full pred_ready", 32'(pred_ready), 32'd0);
        enq(32'h510, 1'b0, 32'h0, 5'b0);
        resolve(32'h500, 0, 0, 0, 0, 32'h0, 5'b0, 1'b0, 32'h0, 5'b0, 1'b0, 1'b0);
        chk("t4 pred_ready after pop", 32'(pred_ready), 32'd1);
        resolve(32'h504, 0, 0, 0, 0, 32'h0, 5'b0, 1'b0, 32'h0, 5'b0, 1'b0, 1'b0);
        resolve(32'h508, 1, 0, 0, 0, 32'h600, 5'b0, 1'b0, 32'h0, 5'b0, 1'b1, 1'b0);
        resolve(32'h50C, 0, 0, 0, 0, 32'h0, 5'b0, 1'b0, 32'h0, 5'b0, 1'b0, 1'b0);

        // Error cases: empty FIFO (0x510 was never accepted), then PC mismatch
        resolve(32'h510, 0, 1, 0, 0, 32'h900, 5'b0, 1'b0, 32'h0, 5'b0, 1'b0, 1'b1);
        enq(32'h600, 1'b0, 32'h0, 5'b0);
        resolve(32'h604, 0, 1, 0, 0, 32'h900, 5'b0, 1'b0, 32'h0, 5'b0, 1'b0, 1'b1);
        resolve(32'h600, 0, 0, 0, 0, 32'h0, 5'b0, 1'b0, 32'h0, 5'b0, 1'b0, 1'b1);
        chk("t5 mispredict_cnt", 32'(mispredict_cnt), 32'd2);
        chk("t5 resolved_cnt", 32'(resolved_cnt), 32'd8);

        // Asynchronous reset while an update pulse is live
        enq(32'h700, 1'b0, 32'h0, 5'b0);
        res_valid = 1'b1; res_pc = 32'h700; res_is_branch = 1'b1; res_is_jal = 1'b0;
        res_is_jalr = 1'b0; res_bcond = 1'b1; res_target = 32'h740;
        @(posedge clk); #1;
        res_valid = 1'b0;
        chk("t6 upd_valid before reset", 32'(upd_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6 upd_valid", 32'(upd_valid), 32'd0);
        chk("t6 upd_target", upd_target, 32'd0);
        chk("t6 upd_tag", 32'(upd_tag), 32'd0);
        chk("t6 err", 32'(err), 32'd0);
        chk("t6 mispredict_cnt", 32'(mispredict_cnt), 32'd0);
        chk("t6 resolved_cnt", 32'(resolved_cnt), 32'd0);
        chk("t6 pred_ready", 32'(pred_ready), 32'd1);
        $display("reset   asserted mid-cycle");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Counter saturation: 19 mispredictions with a 4-bit counter
        for (int i = 0; i < 19; i++) begin
            enq(32'h800, 1'b0, 32'h0, 5'b0);
            resolve(32'h800, 1, 0, 0, 1, 32'h900, 5'b0, 1'b1, 32'h900, 5'b00001, 1'b1, 1'b0);
            if (i == 13) begin
                chk("t7 mispredict_cnt at 14", 32'(mispredict_cnt), 32'd14);
            end
        end
        chk("t7 mispredict_cnt saturated", 32'(mispredict_cnt), 32'hF);
        chk("t7 resolved_cnt saturated", 32'(resolved_cnt), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Resolve side of the branch predictor in the 5-stage pipeline: a DEPTH-entry FIFO holds the prediction made at IF for every fetched instruction.
- When that instruction reaches EX, the unit compares the actual outcome with the prediction.
- On a mismatch it issues flush and redirect, repairs the global history, and one cycle later emits a write transaction that trains the BTB and gshare counters.
- Mispredictions and resolutions are counted for performance reporting.

Parameters:
- ENTRY_BIT, 5, BTB index and global history width.
- DEPTH, 4, prediction FIFO entries; power of 2, at least 2.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- pred_valid  in  1  IF enqueues a prediction this cycle.
- pred_ready  out  1  FIFO not full.
- pred_pc  in  32  fetched PC.
- pred_taken  in  1  predictor chose the target.
- pred_target  in  32  predicted target.
- pred_bhsr  in  ENTRY_BIT  global history snapshot used at prediction time.
- res_valid  in  1  valid instruction in EX this cycle.
- res_pc  in  32  EX PC.
- res_is_branch  in  1  EX instruction is a conditional branch.
- res_is_jal  in  1  EX instruction is jal.
- res_is_jalr  in  1  EX instruction is jalr.
- res_bcond  in  1  branch condition result.
- res_target  in  32  pc+imm for branch/jal, ALU result for jalr.
- is_flush  out  1  misprediction; kill IF/ID.
- redirect_pc  out  32  correct next PC.
- bhsr_restore_valid  out  1  overwrite the global history this cycle.
- bhsr_restore  out  ENTRY_BIT  repaired history value.
- upd_valid  out  1  predictor write strobe.
- upd_idx  out  ENTRY_BIT  BTB index, pc[ENTRY_BIT+1:2].
- upd_tag  out  30-ENTRY_BIT  pc[31:ENTRY_BIT+2].
- upd_target  out  32  resolved target.
- upd_is_branch  out  1  entry is a conditional branch.
- upd_taken  out  1  actual direction.
- upd_cnt_idx  out  ENTRY_BIT  upd_idx ^ snapshot bhsr.
- err  out  1  sticky protocol error.
- mispredict_cnt  out  CNT_W  saturating count of flushes.
- resolved_cnt  out  CNT_W  saturating count of resolutions.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty; head, tail and count = 0; upd_valid=0; all upd_* = 0; err=0; both counters = 0.
- While FIFO is empty after reset: pred_ready=1, is_flush=0, redirect_pc=0, bhsr_restore_valid=0.
- Enqueue: when pred_valid && pred_ready, write {pc, taken, target, bhsr} at tail on the clock edge; tail wraps modulo DEPTH.
- pred_ready = (count != DEPTH). There is no same-cycle bypass.
- Resolution is combinational in the res_valid cycle, applied to the head entry H:
  - actual_taken = jal | jalr | (branch & bcond).
  - actual_next = actual_taken ? res_target : res_pc+4.
  - pred_next = H.taken ? H.target : H.pc+4.
  - is_flush = res_valid & hit & (actual_next != pred_next); redirect_pc = actual_next.
  - hit = count != 0 and H.pc == res_pc.
- Head pop: on res_valid && hit, the head is popped at the clock edge.
- Flush: the whole FIFO is cleared at the edge (count=0, head=tail). Any same-cycle enqueue is discarded as wrong-path.
- History repair: bhsr_restore_valid = is_flush.
  - Branch: bhsr_restore = {H.bhsr[ENTRY_BIT-2:0], res_bcond}.
  - jal/jalr: bhsr_restore = H.bhsr.
- Update transaction: registered, exactly 1 cycle after a hit resolution of a branch, jal or jalr.
  - Asserted regardless of flush.
  - upd_valid pulses for one cycle; fields are held until the next update.
  - upd_is_branch = res_is_branch; upd_taken = actual_taken; upd_target = res_target.
- Non-control instructions: a hit pops the head with no update pulse. A flush is still possible if the predictor chose taken.
- Error cases: res_valid with count==0, or with H.pc != res_pc, sets err.
  - No pop, no flush, no update.
  - err clears only on reset.
- Simultaneous enqueue and non-flush pop: count unchanged; both pointers advance.
- Counters:
  - resolved_cnt increments on each hit resolution.
  - mispredict_cnt increments on each flush.
  - Both saturate at all-ones.
- Reset during operation clears everything immediately, including a pending update pulse.

Test Plan:
- Enqueue pc=0x100 taken=0, then resolve a non-branch at pc=0x100 -> is_flush=0, no upd_valid, count returns to 0.
- Enqueue pc=0x200 taken=0 bhsr=5'b00110; resolve branch bcond=1 target=0x240 -> is_flush=1, redirect_pc=0x240, bhsr_restore=5'b01101; next cycle upd_valid=1, upd_idx=0, upd_cnt_idx=5'b00110, upd_taken=1.
- Enqueue jalr pc=0x300 predicted taken target 0x400; resolve res_target=0x480 -> flush, redirect 0x480, bhsr_restore equals the snapshot; 3 younger entries are discarded and pred_ready=1.
- Enqueue 4 entries without resolution -> pred_ready=0 and a 5th pred_valid is ignored; resolve one correctly predicted entry -> pred_ready=1.
- Resolve with an empty FIFO, or with res_pc mismatching the head -> err=1 sticky, no flush; pull reset low mid-stream -> all outputs return to reset values asynchronously.
- Force 2^CNT_W+3 mispredictions (CNT_W reduced to 4 on the bench) -> mispredict_cnt holds at 4'hF.
